// File: rtl/niosii_system_button_debouncer.sv
// Debounces one active-low DE2 pushbutton for a PIO in_port, with long-press detection.
// Optional auto-repeat is compiled in when BTN_AUTOREPEAT_EN is defined.
module niosii_system_button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_in,
    output logic btn_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    localparam logic [1:0] ST_RELEASED    = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
    localparam logic [1:0] ST_PRESSED     = 2'd2;
    localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);

    logic             s1_q, s2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             btn_q, btn_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             repeat_q, repeat_d;
`endif

    // Two-flop synchroniser; idles high so reset never looks like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= key_n_in;
            s2_q <= s1_q;
        end
    end

    // Debounce / hold FSM next-state logic.
    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        long_d     = long_q;
        btn_d      = btn_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rep_cnt_d  = rep_cnt_q;
        repeat_d   = 1'b0;
`endif
        case (state_q)
            ST_RELEASED: begin
                btn_d = 1'b1;
                if (!s2_q) begin
                    state_d   = ST_PRESS_CHK;
                    deb_cnt_d = CNT_ZERO;
                end else begin
                    state_d = ST_RELEASED;
                end
            end
            ST_PRESS_CHK: begin
                btn_d = 1'b1;
                if (s2_q) begin
                    state_d = ST_RELEASED;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d    = ST_PRESSED;
                    btn_d      = 1'b0;
                    press_d    = 1'b1;
                    hold_cnt_d = CNT_ZERO;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                btn_d = 1'b0;
                if (s2_q) begin
                    state_d   = ST_RELEASE_CHK;
                    deb_cnt_d = CNT_ZERO;
                end else begin
                    if (hold_cnt_q == LONG_MAX) begin
                        long_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_ONE;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    // One-cycle high blip on btn_out gives the PIO a fresh falling edge.
                    if (long_q) begin
                        if (rep_cnt_q == REP_MAX) begin
                            rep_cnt_d = CNT_ZERO;
                            repeat_d  = 1'b1;
                            btn_d     = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + CNT_ONE;
                        end
                    end else begin
                        rep_cnt_d = rep_cnt_q;
                    end
`endif
                end
            end
            ST_RELEASE_CHK: begin
                btn_d = 1'b0;
                if (!s2_q) begin
                    state_d = ST_PRESSED;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d    = ST_RELEASED;
                    btn_d      = 1'b1;
                    release_d  = 1'b1;
                    long_d     = 1'b0;
                    hold_cnt_d = CNT_ZERO;
`ifdef BTN_AUTOREPEAT_EN
                    rep_cnt_d  = CNT_ZERO;
`endif
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                btn_d   = 1'b1;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RELEASED;
            deb_cnt_q  <= CNT_ZERO;
            hold_cnt_q <= CNT_ZERO;
            btn_q      <= 1'b1;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            btn_q      <= btn_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    // Auto-repeat counter and strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt_q <= CNT_ZERO;
            repeat_q  <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            repeat_q  <= repeat_d;
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign btn_out       = btn_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;

endmodule

// File: tb/tb_niosii_system_button_debouncer.sv
// Directed self-checking bench for niosii_system_button_debouncer (DEB=8, LONG=40, REP=10).
module tb_niosii_system_button_debouncer;

    logic clk;
    logic reset;
    logic key_n_in;
    logic btn_out, press_pulse, release_pulse, long_press, repeat_pulse;

    int num_checks;
    int num_errors;
    int pulse_cnt;
    logic exp_rep;

    niosii_system_button_debouncer #(
        .DEBOUNCE_CYCLES(8),
        .LONG_CYCLES    (40),
        .REPEAT_CYCLES  (10),
        .CNT_W          (26)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_n_in     (key_n_in),
        .btn_out      (btn_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_btn"}, {31'd0, btn_out}, 32'd1);
        chk({tag, "_press"}, {31'd0, press_pulse}, 32'd0);
        chk({tag, "_rel"}, {31'd0, release_pulse}, 32'd0);
        chk({tag, "_long"}, {31'd0, long_press}, 32'd0);
        chk({tag, "_rep"}, {31'd0, repeat_pulse}, 32'd0);
    endtask

    // Press the key and verify acceptance exactly 11 edges later.
    task automatic press_and_accept(input string tag);
        key_n_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            chk({tag, "_pre_btn"}, {31'd0, btn_out}, 32'd1);
            chk({tag, "_pre_press"}, {31'd0, press_pulse}, 32'd0);
        end
        tick(1);
        chk({tag, "_acc_btn"}, {31'd0, btn_out}, 32'd0);
        chk({tag, "_acc_press"}, {31'd0, press_pulse}, 32'd1);
        tick(1);
        chk({tag, "_post_press"}, {31'd0, press_pulse}, 32'd0);
        chk({tag, "_post_btn"}, {31'd0, btn_out}, 32'd0);
    endtask

    // Release the key cleanly and verify release exactly 11 edges after the rise.
    task automatic release_and_accept(input string tag, input logic exp_long);
        key_n_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            chk({tag, "_pre_btn"}, {31'd0, btn_out}, 32'd0);
            chk({tag, "_pre_rel"}, {31'd0, release_pulse}, 32'd0);
            chk({tag, "_pre_long"}, {31'd0, long_press}, {31'd0, exp_long});
        end
        tick(1);
        chk({tag, "_acc_btn"}, {31'd0, btn_out}, 32'd1);
        chk({tag, "_acc_rel"}, {31'd0, release_pulse}, 32'd1);
        chk({tag, "_acc_long"}, {31'd0, long_press}, 32'd0);
        tick(1);
        chk({tag, "_post_rel"}, {31'd0, release_pulse}, 32'd0);
    endtask

    initial begin
        num_checks = 0;
        num_errors = 0;
        reset      = 1'b1;
        key_n_in   = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk_idle("reset");

        // 1: reset asserted mid-press clears outputs asynchronously
        press_and_accept("t1_press");
        tick(3);
        reset = 1'b1;
        #1;
        chk_idle("t1_async");
        tick(2);
        key_n_in = 1'b1;
        reset    = 1'b0;
        pulse_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (press_pulse === 1'b1) pulse_cnt++;
        end
        chk("t1_no_press", pulse_cnt, 32'd0);
        chk_idle("t1_after");

        // 2: clean press, hold, release
        press_and_accept("t2_press");
        tick(17);
        chk("t2_hold_btn", {31'd0, btn_out}, 32'd0);
        release_and_accept("t2_rel", 1'b0);

        // 3: short glitch rejected, then real press accepted
        key_n_in = 1'b0;
        tick(5);
        key_n_in  = 1'b1;
        pulse_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (press_pulse === 1'b1 || btn_out !== 1'b1) pulse_cnt++;
        end
        chk("t3_glitch_rejected", pulse_cnt, 32'd0);
        press_and_accept("t3_press");
        tick(5);
        release_and_accept("t3_rel", 1'b0);

        // 4: release bounce, accepted 11 edges after final rise
        press_and_accept("t4_press");
        key_n_in = 1'b1;
        tick(3);
        key_n_in = 1'b0;
        tick(1);
        key_n_in  = 1'b1;
        pulse_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            chk("t4_bounce_btn", {31'd0, btn_out}, 32'd0);
            if (release_pulse === 1'b1) pulse_cnt++;
        end
        tick(1);
        chk("t4_acc_btn", {31'd0, btn_out}, 32'd1);
        if (release_pulse === 1'b1) pulse_cnt++;
        tick(5);
        if (release_pulse === 1'b1) pulse_cnt++;
        chk("t4_one_release", pulse_cnt, 32'd1);

        // 5: long press at 40 edges after acceptance
        press_and_accept("t5_press");
        tick(38);
        chk("t5_long_before", {31'd0, long_press}, 32'd0);
        tick(1);
        chk("t5_long_rise", {31'd0, long_press}, 32'd1);

        // 6: hold 100 more cycles, auto-repeat behaviour
        for (int i = 1; i <= 100; i++) begin
            tick(1);
`ifdef BTN_AUTOREPEAT_EN
            exp_rep = ((i % 10) == 0);
`else
            exp_rep = 1'b0;
`endif
            chk("t6_rep", {31'd0, repeat_pulse}, {31'd0, exp_rep});
            chk("t6_btn", {31'd0, btn_out}, {31'd0, exp_rep});
            chk("t6_long", {31'd0, long_press}, 32'd1);
        end
        release_and_accept("t5_rel", 1'b1);
        tick(2);
        chk_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_errors);
        $finish;
    end

endmodule
